// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the ctrl_unit instruction-sequencing block.
// State codes, opcode map, ALU op codes and the opcode decoder live here.
// Optional build macro: CTRL_UNIT_TRAP_EN (adds the TRAP state).
package ctrl_pkg;

   localparam int OPC_W = 5;
   localparam int ALU_W = 3;

   typedef enum logic [2:0] {
      ST_RESET = 3'd0,
      ST_FETCH = 3'd1,
      ST_DEC   = 3'd2,
      ST_EXEC  = 3'd3,
      ST_MWAIT = 3'd4
`ifdef CTRL_UNIT_TRAP_EN
      , ST_TRAP = 3'd5
`endif
   } state_t;

   // Opcode map; 11000..11111 are reserved and behave as NOP (or trap).
   localparam logic [OPC_W-1:0] OP_NOP  = 5'b00000;
   localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
   localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
   localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
   localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
   localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
   localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
   localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;
   localparam logic [OPC_W-1:0] OP_NOT  = 5'b01000;
   localparam logic [OPC_W-1:0] OP_AND  = 5'b01001;
   localparam logic [OPC_W-1:0] OP_ANDI = 5'b01010;
   localparam logic [OPC_W-1:0] OP_OR   = 5'b01011;
   localparam logic [OPC_W-1:0] OP_ORI  = 5'b01100;
   localparam logic [OPC_W-1:0] OP_XOR  = 5'b01101;
   localparam logic [OPC_W-1:0] OP_XORI = 5'b01110;
   localparam logic [OPC_W-1:0] OP_SLL  = 5'b01111;
   localparam logic [OPC_W-1:0] OP_SRL  = 5'b10000;
   localparam logic [OPC_W-1:0] OP_BEQ  = 5'b10001;
   localparam logic [OPC_W-1:0] OP_BNE  = 5'b10010;
   localparam logic [OPC_W-1:0] OP_BGT  = 5'b10011;
   localparam logic [OPC_W-1:0] OP_BGE  = 5'b10100;
   localparam logic [OPC_W-1:0] OP_BLT  = 5'b10101;
   localparam logic [OPC_W-1:0] OP_BLE  = 5'b10110;
   localparam logic [OPC_W-1:0] OP_JMP  = 5'b10111;

   // ALU operation codes
   localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_W-1:0] ALU_NOT = 3'b010;
   localparam logic [ALU_W-1:0] ALU_AND = 3'b011;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'b100;
   localparam logic [ALU_W-1:0] ALU_XOR = 3'b101;
   localparam logic [ALU_W-1:0] ALU_SLL = 3'b110;
   localparam logic [ALU_W-1:0] ALU_SRL = 3'b111;

   // Accumulator source select
   localparam logic [1:0] SELA_MEM = 2'b00;
   localparam logic [1:0] SELA_IMM = 2'b01;
   localparam logic [1:0] SELA_ALU = 2'b10;

   typedef struct packed {
      logic [ALU_W-1:0] alu_op;
      logic [1:0]       sel_a;
      logic             sel_b;
      logic             wr_acc;
      logic             is_ld;
      logic             is_sto;
      logic             is_branch;
   } dec_t;

   function automatic dec_t alu_dec(input logic [ALU_W-1:0] op, input logic sel_b);
      dec_t d;
      d        = '0;
      d.alu_op = op;
      d.sel_a  = SELA_ALU;
      d.sel_b  = sel_b;
      d.wr_acc = 1'b1;
      return d;
   endfunction

   // Static decode of an opcode; unlisted codes decode to "no effect".
   function automatic dec_t decode_op(input logic [OPC_W-1:0] opc);
      dec_t d;
      d = '0;
      case (opc)
         OP_ADD:  d = alu_dec(ALU_ADD, 1'b0);
         OP_ADDI: d = alu_dec(ALU_ADD, 1'b1);
         OP_SUB:  d = alu_dec(ALU_SUB, 1'b0);
         OP_SUBI: d = alu_dec(ALU_SUB, 1'b1);
         OP_NOT:  d = alu_dec(ALU_NOT, 1'b0);
         OP_AND:  d = alu_dec(ALU_AND, 1'b0);
         OP_ANDI: d = alu_dec(ALU_AND, 1'b1);
         OP_OR:   d = alu_dec(ALU_OR,  1'b0);
         OP_ORI:  d = alu_dec(ALU_OR,  1'b1);
         OP_XOR:  d = alu_dec(ALU_XOR, 1'b0);
         OP_XORI: d = alu_dec(ALU_XOR, 1'b1);
         OP_SLL:  d = alu_dec(ALU_SLL, 1'b1);
         OP_SRL:  d = alu_dec(ALU_SRL, 1'b1);
         OP_LDI: begin
            d.alu_op = ALU_ADD;
            d.sel_a  = SELA_IMM;
            d.sel_b  = 1'b1;
            d.wr_acc = 1'b1;
         end
         OP_LD: begin
            d.sel_a  = SELA_MEM;
            d.wr_acc = 1'b1;
            d.is_ld  = 1'b1;
         end
         OP_STO: d.is_sto = 1'b1;
         OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP: d.is_branch = 1'b1;
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/ctrl_if.sv
// ctrl_if: opcode and status-flag bus between the sequencer and the branch
// condition evaluator. The master drives opcode/flags, the slave returns
// 'take' combinationally in the same cycle (no handshake, pure level bus).
interface ctrl_if;
   import ctrl_pkg::*;

   logic [OPC_W-1:0] opcode;
   logic             n;
   logic             z;
   logic             take;

   modport master (output opcode, output n, output z, input take);
   modport slave  (input opcode, input n, input z, output take);

endinterface

// File: rtl/ctrl_branch_eval.sv
// branch_eval: decides whether the branch opcode on the bus is taken from
// the negative/zero flags. Non-branch opcodes never report 'take'.
module branch_eval
   import ctrl_pkg::*;
(
   ctrl_if.slave br
);

   // Flag condition per branch opcode
   always_comb begin
      br.take = 1'b0;
      case (br.opcode)
         OP_BEQ:  br.take = br.z;
         OP_BNE:  br.take = ~br.z;
         OP_BGT:  br.take = ~br.n & ~br.z;
         OP_BGE:  br.take = ~br.n;
         OP_BLT:  br.take = br.n;
         OP_BLE:  br.take = br.n | br.z;
         OP_JMP:  br.take = 1'b1;
         default: br.take = 1'b0;
      endcase
   end

endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle instruction sequencer (FETCH/DEC/EXEC/MWAIT) that
// produces PC/accumulator strobes, ALU selects and active-low memory enables.
// A sticky timeout aborts an instruction after WAIT_MAX not-ready cycles.
// Optional build macro: CTRL_UNIT_TRAP_EN (reserved opcodes lock into TRAP).
module ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int OPCODE_WIDTH  = 5,
   parameter int SEL_OPERATION = 3,
   parameter int SEL_WIDTH     = 2,
   parameter int WAIT_MAX      = 7
) (
   input  logic                     clock_i,
   input  logic                     nreset_i,
   input  logic [OPCODE_WIDTH-1:0]  opcode_i,
   input  logic                     hold_i,
   input  logic                     n_i,
   input  logic                     z_i,
   input  logic                     mem_ready_i,
   output logic                     branch_o,
   output logic                     wrPC_o,
   output logic [SEL_WIDTH-1:0]     selA_o,
   output logic                     selB_o,
   output logic                     wrAccA_o,
   output logic [SEL_OPERATION-1:0] op_o,
   output logic                     im_OEn,
   output logic                     im_CEn,
   output logic                     dm_OEn,
   output logic                     dm_CEn,
   output logic                     dm_WEn,
   output logic [2:0]               state_o,
   output logic                     timeout_o
);

   // The timeout fires on the WAIT_MAX-th consecutive not-ready cycle,
   // i.e. when the count of earlier not-ready cycles equals WAIT_MAX-1.
   localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX - 1);

   // Illegal configurations stop elaboration.
   if (WAIT_MAX < 1 || WAIT_MAX > 255 || DATA_WIDTH < 1) begin : g_cfg_err
      $error("ctrl_unit: WAIT_MAX must be 1..255 and DATA_WIDTH >= 1");
   end

   state_t           r_state;
   state_t           w_state_next;
   logic [7:0]       r_wait_cnt;
   logic [7:0]       w_wait_cnt_next;
   logic             r_timeout;
   logic [OPC_W-1:0] w_opc;
   dec_t             w_dec;
   logic             w_take;
   logic             w_hold;
   logic             w_waiting;
   logic             w_tmo;
   logic             w_mem_op;
   logic             w_mem_phase;
   logic             w_done;

   assign w_opc    = OPC_W'(opcode_i);
   assign w_dec    = decode_op(w_opc);
   assign w_mem_op = w_dec.is_ld | w_dec.is_sto;

   // Freeze applies everywhere except RESET.
   assign w_hold    = hold_i & (r_state != ST_RESET);
   assign w_waiting = ((r_state == ST_FETCH) || (r_state == ST_MWAIT)) & ~mem_ready_i;
   assign w_tmo     = w_waiting & ~w_hold & (r_wait_cnt == WAIT_LIM);

   ctrl_if w_br_if ();
   assign w_br_if.opcode = w_opc;
   assign w_br_if.n      = n_i;
   assign w_br_if.z      = z_i;
   assign w_take         = w_br_if.take;

   branch_eval u_branch_eval (
      .br (w_br_if.slave)
   );

   // State, wait counter and sticky timeout registers
   always_ff @(posedge clock_i or negedge nreset_i) begin
      if (!nreset_i) begin
         r_state    <= ST_RESET;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_cnt_next;
         r_timeout  <= r_timeout | w_tmo;
      end
   end

   // Next-state logic; a held cycle keeps the current state
   always_comb begin
      w_state_next = r_state;
      if (!w_hold) begin
         case (r_state)
            ST_RESET: w_state_next = ST_FETCH;
            ST_FETCH: begin
               // A timeout in FETCH restarts the fetch, so only ready moves on.
               if (mem_ready_i) w_state_next = ST_DEC;
            end
            ST_DEC: begin
               w_state_next = ST_EXEC;
`ifdef CTRL_UNIT_TRAP_EN
               if (w_opc[4:3] == 2'b11) w_state_next = ST_TRAP;
`endif
            end
            ST_EXEC: begin
               if (w_mem_op && !mem_ready_i) w_state_next = ST_MWAIT;
               else                          w_state_next = ST_FETCH;
            end
            ST_MWAIT: begin
               if (mem_ready_i || w_tmo) w_state_next = ST_FETCH;
            end
`ifdef CTRL_UNIT_TRAP_EN
            ST_TRAP: w_state_next = ST_TRAP;
`endif
            default: w_state_next = ST_RESET;
         endcase
      end
   end

   // Wait counter: counts consecutive not-ready cycles, cleared on state change or timeout
   always_comb begin
      w_wait_cnt_next = r_wait_cnt;
      if (!w_hold) begin
         if (w_tmo || !w_waiting || (w_state_next != r_state)) w_wait_cnt_next = '0;
         else                                                  w_wait_cnt_next = r_wait_cnt + 8'd1;
      end
   end

   // Output decode from registered state and the current opcode
   always_comb begin
      w_mem_phase = ((r_state == ST_EXEC) || (r_state == ST_MWAIT)) & w_mem_op;
      w_done      = 1'b0;
      if (!w_hold) begin
         if (r_state == ST_EXEC)  w_done = ~(w_mem_op & ~mem_ready_i);
         if (r_state == ST_MWAIT) w_done = mem_ready_i;
      end

      wrPC_o    = w_done;
      wrAccA_o  = w_done & w_dec.wr_acc;
      branch_o  = w_done & w_dec.is_branch & w_take;

      op_o      = SEL_OPERATION'(w_dec.alu_op);
      selA_o    = SEL_WIDTH'(w_dec.sel_a);
      selB_o    = w_dec.sel_b;

      im_CEn    = ~(r_state == ST_FETCH);
      im_OEn    = ~(r_state == ST_FETCH);
      dm_CEn    = ~w_mem_phase;
      dm_OEn    = ~(w_mem_phase & w_dec.is_ld);
      dm_WEn    = ~(w_mem_phase & w_dec.is_sto & ~w_tmo);

      state_o   = r_state;
      timeout_o = r_timeout;
   end

endmodule

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, datapath width.
REQ-002 SHALL have parameter OPCODE_WIDTH, default 5, opcode field width.
REQ-003 SHALL have parameter SEL_OPERATION, default 3, ALU op select width.
REQ-004 SHALL have parameter SEL_WIDTH, default 2, accumulator mux select width.
REQ-005 SHALL have parameter WAIT_MAX, default 7, maximum memory wait cycles before timeout (1..255).
REQ-006 SHALL have ports, in order:
- clock_i, in, 1, single clock; all state on its rising edge.
- nreset_i, in, 1, reset; asynchronous and active-low.
- opcode_i, in, OPCODE_WIDTH, current instruction opcode.
- hold_i, in, 1, freeze request.
- n_i, in, 1, negative flag.
- z_i, in, 1, zero flag.
- mem_ready_i, in, 1, memory access complete.
- branch_o, out, 1, take branch target.
- wrPC_o, out, 1, PC write strobe.
- selA_o, out, SEL_WIDTH, accumulator source: 00 memory, 01 immediate, 10 ALU.
- selB_o, out, 1, ALU B source: 1 immediate.
- wrAccA_o, out, 1, accumulator write strobe.
- op_o, out, SEL_OPERATION, ALU op.
- im_OEn, out, 1, instruction memory output enable, active-low.
- im_CEn, out, 1, instruction memory chip enable, active-low.
- dm_OEn, out, 1, data memory output enable, active-low.
- dm_CEn, out, 1, data memory chip enable, active-low.
- dm_WEn, out, 1, data memory write enable, active-low.
- state_o, out, 3, current state code.
- timeout_o, out, 1, sticky memory timeout flag.

Function
REQ-007 SHALL implement states RESET=0, FETCH=1, DEC=2, EXEC=3, MWAIT=4, TRAP=5.
REQ-008 SHALL transition RESET->FETCH unconditionally.
REQ-009 SHALL stay in FETCH until mem_ready_i=1, then go to DEC.
REQ-010 SHALL transition DEC->EXEC unconditionally.
REQ-011 SHALL transition EXEC->FETCH, except LD (00010) and STO (00001) with mem_ready_i=0, which go to MWAIT.
REQ-012 SHALL transition MWAIT->FETCH when mem_ready_i=1.
REQ-013 SHALL hold the state and wait counter whenever hold_i=1 in any state except RESET, and SHALL deassert wrPC_o and wrAccA_o during that cycle.
REQ-014 SHALL count consecutive not-ready cycles in FETCH and MWAIT with an 8-bit counter, cleared on every state change.
- At count==WAIT_MAX: set timeout_o, go to FETCH, and issue no wrAccA_o, wrPC_o or dm_WEn strobe for that instruction.
REQ-015 SHALL drive outputs combinationally from the registered state and opcode_i.
REQ-016 SHALL decode ops as follows (op_o / selA_o / selB_o):
- ADD 000/10/0, ADDI 000/10/1, SUB 001/10/0, SUBI 001/10/1.
- NOT 010/10/0, AND 011/10/0, ANDI 011/10/1, OR 100/10/0, ORI 100/10/1.
- XOR 101/10/0, XORI 101/10/1, SLL 110/10/1, SRL 111/10/1.
- LDI 000/01/1, LD 000/00/0.
REQ-017 SHALL pulse wrPC_o for exactly one cycle per instruction: in EXEC, or in MWAIT on the ready cycle. wrAccA_o SHALL pulse in the same cycle for ALU ops, LD and LDI.
REQ-018 SHALL set branch_o with wrPC_o when the condition holds:
- BEQ z; BNE !z; BGT !n&!z; BGE !n; BLT n; BLE n|z; JMP always.
- Branches SHALL never assert wrAccA_o.
REQ-019 SHALL drive memory enables as follows:
- im_CEn/im_OEn low in FETCH only.
- dm_CEn low in EXEC/MWAIT for LD/STO.
- dm_OEn low for LD.
- dm_WEn low for STO in EXEC/MWAIT.
- All others high.
REQ-020 SHALL treat NOP and opcodes 11000..11111 as no-op: wrPC_o only.

Reset
REQ-021 SHALL, on nreset_i=0, immediately enter RESET, clear the counter and timeout_o, and drive all strobes 0 and all active-low enables 1, including mid-MWAIT.

Configuration
REQ-022 SHALL, with CTRL_UNIT_TRAP_EN defined, send opcodes 11000..11111 from DEC to TRAP, which holds with all enables high and no strobes until reset. Without the macro, TRAP SHALL not exist and REQ-020 SHALL apply.

Structure
REQ-023 SHALL place the state codes, opcode constants and ALU op constants in package ctrl_pkg.
REQ-024 SHALL place the branch condition logic in sub-module branch_eval.

Verification
REQ-025 SHALL cover: ADDI with mem_ready_i=1 -> FETCH, DEC, EXEC in 3 cycles; op_o=000, selB_o=1, wrAccA_o=1 in EXEC.
REQ-026 SHALL cover: LD with ready 2 cycles late in EXEC -> MWAIT for 2 cycles; wrAccA_o=1 and wrPC_o=1 on the ready cycle only.
REQ-027 SHALL cover: BLE with n=0, z=1 -> branch_o=1; with n=0, z=0 -> branch_o=0, wrPC_o=1.
REQ-028 SHALL cover: mem_ready_i=0 for 7 cycles in FETCH -> timeout_o=1, back to FETCH, no strobes.
REQ-029 SHALL cover: hold_i=1 for 3 cycles in EXEC -> state_o=3 throughout, no strobes, then a normal single pulse.
REQ-030 SHALL cover: nreset_i low mid-MWAIT for STO -> dm_WEn=1 and state_o=0 immediately.
